wb_stream_fifo_fwft: RTL
========================

Name: wb_stream_fifo_fwft

Overview:
- Parametrised single-clock stream FIFO with a first-word-fall-through master side.
- Next generation of the writer-side stream buffer. The vendor FIFO core and the separate FWFT adapter are replaced by one generic block with inferred RAM and any power-of-two depth.
- Adds an exact fill count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags.
- Sits between the Wishbone stream reader/writer and the pixel/SD data paths.

Parameters:
- DW, 32, data width in bits.
- AW, 9, depth exponent; total capacity DEPTH = 2^AW words.
- AF_THR, 2^AW-4, almost_full_o asserts when cnt >= AF_THR.
- AE_THR, 4, almost_empty_o asserts when cnt <= AE_THR.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- stream_s_data_i  in  DW  slave (write-side) data.
- stream_s_valid_i  in  1  slave data valid.
- stream_s_ready_o  out  1  slave ready; high when cnt < DEPTH.
- stream_m_data_o  out  DW  master (read-side) data, registered.
- stream_m_valid_o  out  1  master data valid.
- stream_m_ready_i  in  1  master ready.
- cnt  out  AW+1  words held, including the word in the output register; range 0..DEPTH.
- almost_full_o  out  1  cnt >= AF_THR, registered.
- almost_empty_o  out  1  cnt <= AE_THR, registered.
- err_o  out  2  sticky flags: bit0 overflow (valid while !ready), bit1 underflow (ready while !valid with cnt>0 mismatch); cleared only by reset.

Behaviour:
- Reset (rst_n low at a clock edge):
  - RAM pointers, cnt and err_o clear to 0.
  - stream_m_valid_o=0, stream_m_data_o=0, almost_full_o=0, almost_empty_o=1, stream_s_ready_o=1 on the next cycle.
  - RAM contents are not cleared.
  - Reset mid-transfer discards all stored words; no partial word reaches the master side.
- Write and read acceptance:
  - Write accepted when stream_s_valid_i & stream_s_ready_o.
  - Read accepted when stream_m_valid_o & stream_m_ready_i.
- Storage: dual-port RAM of DEPTH words plus one output register. The output register is refilled from RAM via a synchronous read; capacity seen at the ports is exactly DEPTH.
- Latency:
  - Word accepted at edge N into an empty FIFO gives stream_m_valid_o=1 with that word after edge N+2.
  - Back-to-back reads at full rate sustain 1 word/clk with no bubbles while cnt > 1.
- Master-side rules:
  - stream_m_data_o and stream_m_valid_o hold stable while valid & !ready (AXI-style hold).
  - valid never drops without a read accept.
- cnt:
  - Increments on write-only, decrements on read-only, unchanged when both happen in the same cycle.
  - Never wraps: write is impossible at DEPTH and read impossible at 0.
- stream_s_ready_o = (cnt != DEPTH), registered from next-state cnt.
  - When full with a simultaneous read, ready rises on the following cycle, not the same cycle.
- Pointers are AW bits and wrap modulo DEPTH naturally. Full/empty is derived from cnt, not pointer compare.
- Empty with simultaneous write: no read occurs; valid follows the 2-cycle latency.
- Flag timing: almost_full_o and almost_empty_o update one cycle after the cnt change they reflect.
- err_o[0]: set if stream_s_valid_i=1 while stream_s_ready_o=0 for more than 0 cycles. It is informational only: the upstream is allowed to stall with valid held.
- Do not modify state on illegal input; dropped data is never written.

Optional Feature:
- Macro: WB_STREAM_FIFO_PKT_EN.
- Defined:
  - Adds ports stream_s_last_i (in, 1) and stream_m_last_o (out, 1). last is stored as bit DW of each RAM word.
  - Adds output pkt_cnt (AW+1), the number of complete packets held. It increments on an accepted write with last=1 and decrements on an accepted read with last=1.
  - stream_m_valid_o is gated low until pkt_cnt > 0 (store-and-forward). Data already in the output register is held, not lost.
  - If the FIFO becomes full with pkt_cnt = 0, the gate opens (prevents deadlock) and err_o bit1 is set.
- Undefined: no last ports, no pkt_cnt, cut-through behaviour as above, RAM width DW.

Test Plan:
- Reset, then write 0x11,0x22,0x33 with m_ready=0 → m_valid high 2 cycles after the first write, m_data=0x11 held; cnt=3. Then m_ready=1 → reads 0x11,0x22,0x33 on consecutive cycles, cnt=0, almost_empty_o=1.
- AW=4, write 16 words with m_ready=0 → s_ready=0 at cnt=16, almost_full_o=1 (AF_THR=12) from the cycle after cnt=12. One read → s_ready=1 one cycle later.
- Continuous valid/ready on both sides for 1000 cycles with an incrementing pattern → no gaps after fill, cnt stable, data in order, pointer wrap exercised.
- Assert rst_n=0 for one cycle with cnt=7 and m_valid=1 → next cycle m_valid=0, cnt=0, s_ready=1, err_o=0. A subsequent write of 0xAA is read out first.
- Hold s_valid=1 while full for 3 cycles → err_o[0]=1 and sticky; no word overwritten (readout matches the original 16 words).
- With WB_STREAM_FIFO_PKT_EN: write a 4-word packet, last on word 4 → m_valid stays 0 until after word 4 is written, then 4 words stream out with m_last on the 4th; pkt_cnt 1→0.

Source files
------------

// File: rtl/wb_stream_fifo_fwft.sv
// wb_stream_fifo_fwft: single-clock stream FIFO, inferred dual-port RAM + FWFT output register.
// Latency: a word written at edge N is presented on the master side after edge N+2; 1 word/clk sustained.
// Backpressure: stream_s_ready_o drops at cnt==DEPTH; master data/valid hold while valid & !ready.
// Optional build macro WB_STREAM_FIFO_PKT_EN: last-bit storage, pkt_cnt and store-and-forward gating.
module wb_stream_fifo_fwft #(
   parameter int DW     = 32,
   parameter int AW     = 9,
   parameter int AF_THR = (1 << AW) - 4,
   parameter int AE_THR = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] stream_s_data_i,
   input  logic          stream_s_valid_i,
`ifdef WB_STREAM_FIFO_PKT_EN
   input  logic          stream_s_last_i,
   output logic          stream_m_last_o,
   output logic [AW:0]   pkt_cnt,
`endif
   output logic          stream_s_ready_o,
   output logic [DW-1:0] stream_m_data_o,
   output logic          stream_m_valid_o,
   input  logic          stream_m_ready_i,
   output logic [AW:0]   cnt,
   output logic          almost_full_o,
   output logic          almost_empty_o,
   output logic [1:0]    err_o
);

   localparam int DEPTH = 1 << AW;
`ifdef WB_STREAM_FIFO_PKT_EN
   localparam int RW = DW + 1;   // bit DW carries the packet last flag
`else
   localparam int RW = DW;
`endif
   localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
   localparam logic [AW:0] AF_C   = (AW+1)'(AF_THR);
   localparam logic [AW:0] AE_C   = (AW+1)'(AE_THR);

   logic [RW-1:0] mem [DEPTH];
   logic [RW-1:0] ram_q;       // synchronous RAM read data (prefetch stage)
   logic [RW-1:0] out_q;       // master-side output register
   logic [RW-1:0] wr_word;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          q_vld;       // ram_q holds a word not yet moved to out_q
   logic          out_vld;     // out_q holds a word not yet read
   logic          wr_en;
   logic          rd_acc;
   logic          mv_q;
   logic          ram_rd;
   logic          gate_ok;
   logic          err1_set;
   logic [AW:0]   ram_words;
   logic [AW:0]   cnt_n;

`ifdef WB_STREAM_FIFO_PKT_EN
   logic          gate_open;   // forced cut-through after filling with no complete packet
   logic          gate_open_n;
   logic [AW:0]   pkt_cnt_n;
   logic          pkt_in;
   logic          pkt_out;
`endif

   // Handshakes, prefetch pipeline moves and next-state fill count.
   always_comb begin
      wr_en     = stream_s_valid_i & stream_s_ready_o;
`ifdef WB_STREAM_FIFO_PKT_EN
      gate_ok   = (pkt_cnt != '0) | gate_open;
      wr_word   = {stream_s_last_i, stream_s_data_i};
`else
      gate_ok   = 1'b1;
      wr_word   = stream_s_data_i;
`endif
      stream_m_valid_o = out_vld & gate_ok;
      rd_acc    = stream_m_valid_o & stream_m_ready_i;
      // Words still inside the RAM: total minus the two register stages.
      ram_words = cnt - (AW+1)'(q_vld) - (AW+1)'(out_vld);
      mv_q      = q_vld & (~out_vld | rd_acc);
      ram_rd    = (ram_words != '0) & (~q_vld | mv_q);
      cnt_n     = cnt;
      if (wr_en & ~rd_acc) begin
         cnt_n = cnt + 1'b1;
      end else if (rd_acc & ~wr_en) begin
         cnt_n = cnt - 1'b1;
      end
      err1_set  = stream_m_ready_i & ~stream_m_valid_o & (cnt != '0);
`ifdef WB_STREAM_FIFO_PKT_EN
      err1_set  = err1_set | ((cnt == FULL_C) & (pkt_cnt == '0));
`endif
   end

`ifdef WB_STREAM_FIFO_PKT_EN
   // Packet count and the anti-deadlock gate override.
   always_comb begin
      pkt_in      = wr_en & stream_s_last_i;
      pkt_out     = rd_acc & out_q[DW];
      pkt_cnt_n   = pkt_cnt;
      if (pkt_in & ~pkt_out) begin
         pkt_cnt_n = pkt_cnt + 1'b1;
      end else if (pkt_out & ~pkt_in) begin
         pkt_cnt_n = pkt_cnt - 1'b1;
      end
      gate_open_n = gate_open;
      if ((cnt == FULL_C) && (pkt_cnt == '0)) begin
         gate_open_n = 1'b1;
      end else if (cnt_n == '0) begin
         gate_open_n = 1'b0;
      end
   end

   assign stream_m_last_o = out_q[DW];
`endif

   assign stream_m_data_o = out_q[DW-1:0];

   // Inferred dual-port RAM: contents are never reset; writes are blocked while in reset.
   always_ff @(posedge clk) begin
      if (wr_en && rst_n) begin
         mem[wr_ptr] <= wr_word;
      end
      if (ram_rd) begin
         ram_q <= mem[rd_ptr];
      end
   end

   // Control state, registered flags and sticky errors with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         cnt              <= '0;
         q_vld            <= 1'b0;
         out_vld          <= 1'b0;
         out_q            <= '0;
         stream_s_ready_o <= 1'b1;
         almost_full_o    <= 1'b0;
         almost_empty_o   <= 1'b1;
         err_o            <= 2'b00;
`ifdef WB_STREAM_FIFO_PKT_EN
         pkt_cnt          <= '0;
         gate_open        <= 1'b0;
`endif
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (ram_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (mv_q) begin
            out_q <= ram_q;
         end
         cnt              <= cnt_n;
         q_vld            <= ram_rd | (q_vld & ~mv_q);
         out_vld          <= mv_q | (out_vld & ~rd_acc);
         stream_s_ready_o <= (cnt_n != FULL_C);
         almost_full_o    <= (cnt >= AF_C);
         almost_empty_o   <= (cnt <= AE_C);
         err_o[0]         <= err_o[0] | (stream_s_valid_i & ~stream_s_ready_o);
         err_o[1]         <= err_o[1] | err1_set;
`ifdef WB_STREAM_FIFO_PKT_EN
         pkt_cnt          <= pkt_cnt_n;
         gate_open        <= gate_open_n;
`endif
      end
   end

endmodule
